// File: rtl/im_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the loader.
// master: stream source and memory side; slave: the loader.
interface im_loader_if #(
  parameter int ADDR_W = 5
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: framed little-endian byte stream -> sequential
// word writes, checksum-verified, with the core held in reset while loading.
module im_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_reset_n,
  im_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   word_cnt;
  logic [1:0]        byte_idx;
  logic [31:0]       word_reg;
  logic [7:0]        acc;
  logic              xfer;

  assign xfer = bus.byte_valid && bus.byte_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_COUNT;
      S_COUNT: begin
        if (xfer) begin
          if (bus.byte_in == 8'd0 || int'(bus.byte_in) > DEPTH) state_next = S_ERROR;
          else                                                   state_next = S_DATA;
        end
      end
      S_DATA:  if (xfer && byte_idx == 2'd3) state_next = S_WRITE;
      S_WRITE: begin
        if (word_cnt == n_words - 1'b1) state_next = S_CHECK;
        else                            state_next = S_DATA;
      end
      S_CHECK: if (xfer) state_next = (bus.byte_in == acc) ? S_DONE : S_ERROR;
      S_DONE, S_ERROR: if (start) state_next = S_COUNT;
      default: state_next = S_IDLE;
    endcase
  end

  // byte_idx wraps 3->0 on its own, so WRITE needs no explicit index clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      n_words  <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      word_reg <= '0;
      acc      <= '0;
    end else begin
      case (state)
        S_COUNT: begin
          if (xfer && state_next == S_DATA) begin
            n_words  <= bus.byte_in[ADDR_W:0];
            word_cnt <= '0;
            byte_idx <= '0;
            acc      <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            word_reg[8*byte_idx +: 8] <= bus.byte_in;
            acc                       <= acc ^ bus.byte_in;
            byte_idx                  <= byte_idx + 2'd1;
          end
        end
        S_WRITE: word_cnt <= word_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.byte_ready = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
    bus.im_we      = (state == S_WRITE);
    bus.im_addr    = word_cnt[ADDR_W-1:0];
    bus.im_wdata   = word_reg;
    busy           = (state == S_COUNT) || (state == S_DATA) ||
                     (state == S_WRITE) || (state == S_CHECK);
    done           = (state == S_DONE);
    error          = (state == S_ERROR);
    cpu_reset_n    = (state == S_IDLE) || (state == S_DONE);
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: frame loads, checksum/count errors,
// back-pressure, start ignored mid-load, and reset mid-load.
module tb_im_loader;

  logic clk = 1'b0;
  logic reset_n, start;
  logic busy, done, error, cpu_reset_n;

  im_loader_if #(.ADDR_W(5)) bus ();

  im_loader #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cpu_reset_n (cpu_reset_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log captured mid-cycle, away from the active edge.
  logic [4:0]  log_addr [0:127];
  logic [31:0] log_data [0:127];
  int n_wr          = 0;
  int ready_in_write = 0;
  always @(negedge clk) begin
    if (bus.im_we && n_wr < 128) begin
      log_addr[n_wr] = bus.im_addr;
      log_data[n_wr] = bus.im_wdata;
      if (bus.byte_ready) ready_in_write++;
      n_wr++;
    end
  end

  logic [31:0] frame_words [0:63];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no end of test, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] csum_of(input int n);
    logic [7:0]  c;
    logic [31:0] w;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      c = c ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    return c;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns #1 after the edge on which the byte transferred.
  task automatic send_byte(input logic [7:0] b, input bit bp);
    int w;
    if (bp) begin
      repeat ($urandom_range(0, 1)) begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    w = 0;
    while (!bus.byte_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) begin
      n_assert++;
      n_fail++;
      $display("FAIL byte_wait: observed byte_ready=0 for %0d cycles, expected 1", w);
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] cs, input bit bp, input int start_at);
    logic [31:0] w;
    int idx;
    send_byte(8'(n), bp);
    idx = 0;
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      for (int j = 0; j < 4; j++) begin
        if (idx == start_at) begin
          bus.byte_valid = 1'b0;
          pulse_start();
        end
        send_byte(w[8*j +: 8], bp);
        idx++;
      end
    end
    send_byte(cs, bp);
  endtask

  task automatic check_writes(input string tag, input int base, input int n);
    check({tag, "_nwr"}, 32'(n_wr - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, 32'(log_addr[base + i]), 32'(i));
      check({tag, "_data"}, log_data[base + i], frame_words[i]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_we"},    32'(bus.im_we),      32'd0);
    check({tag, "_addr"},  32'(bus.im_addr),    32'd0);
    check({tag, "_wdata"}, bus.im_wdata,        32'd0);
    check({tag, "_busy"},  32'(busy),           32'd0);
    check({tag, "_done"},  32'(done),           32'd0);
    check({tag, "_error"}, 32'(error),          32'd0);
    check({tag, "_cpurst"}, 32'(cpu_reset_n),   32'd1);
  endtask

  initial begin
    int base;
    int t_count;
    logic [31:0] w;

    reset_n = 1'b0;
    start   = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 32'(bus.byte_ready), 32'd0);

    // Basic load, byte_valid held high
    frame_words[0] = 32'hD280_0020;
    frame_words[1] = 32'h8B01_0002;
    base = n_wr;
    pulse_start();
    t_count = cyc;
    check("count_ready", 32'(bus.byte_ready), 32'd1);
    check("count_cpurst", 32'(cpu_reset_n), 32'd0);
    check("count_busy", 32'(busy), 32'd1);
    send_frame(2, csum_of(2), 1'b0, -1);
    check("basic_latency", 32'(cyc - t_count), 32'd12);
    check("basic_done", 32'(done), 32'd1);
    check("basic_cpurst", 32'(cpu_reset_n), 32'd1);
    check("basic_busy", 32'(busy), 32'd0);
    check("basic_error", 32'(error), 32'd0);
    check_writes("basic", base, 2);

    // Checksum mismatch, then recovery
    base = n_wr;
    pulse_start();
    send_frame(2, 8'h00, 1'b0, -1);
    check_writes("badcs", base, 2);
    check("badcs_error", 32'(error), 32'd1);
    check("badcs_cpurst", 32'(cpu_reset_n), 32'd0);
    check("badcs_done", 32'(done), 32'd0);
    check("badcs_busy", 32'(busy), 32'd0);
    base = n_wr;
    pulse_start();
    check("restart_error", 32'(error), 32'd0);
    send_frame(2, csum_of(2), 1'b0, -1);
    check("recover_done", 32'(done), 32'd1);
    check("recover_error", 32'(error), 32'd0);
    check_writes("recover", base, 2);

    // Bad counts
    base = n_wr;
    pulse_start();
    send_byte(8'd0, 1'b0);
    check("n0_error", 32'(error), 32'd1);
    check("n0_cpurst", 32'(cpu_reset_n), 32'd0);
    check("n0_busy", 32'(busy), 32'd0);
    pulse_start();
    send_byte(8'd33, 1'b0);
    check("n33_error", 32'(error), 32'd1);
    check("n33_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("badn_nwr", 32'(n_wr - base), 32'd0);

    // Full memory, word i = i
    for (int i = 0; i < 32; i++) frame_words[i] = 32'(i);
    base = n_wr;
    pulse_start();
    send_frame(32, csum_of(32), 1'b0, -1);
    check_writes("full", base, 32);
    check("full_last_addr", 32'(log_addr[base + 31]), 32'd31);
    check("full_done", 32'(done), 32'd1);

    // Back-pressure, with a start pulse while stalled in DATA
    frame_words[0] = 32'hD280_0020;
    frame_words[1] = 32'h8B01_0002;
    base = n_wr;
    pulse_start();
    send_frame(2, csum_of(2), 1'b1, 2);
    check_writes("bp", base, 2);
    check("bp_done", 32'(done), 32'd1);
    check("bp_error", 32'(error), 32'd0);
    check("ready_in_write", 32'(ready_in_write), 32'd0);

    // Mid-load reset after 6 data bytes; start in DATA must be ignored
    base = n_wr;
    pulse_start();
    send_byte(8'd2, 1'b0);
    w = frame_words[0];
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b0);
    check("wr_we", 32'(bus.im_we), 32'd1);
    check("wr_addr", 32'(bus.im_addr), 32'd0);
    check("wr_wdata", bus.im_wdata, 32'hD280_0020);
    check("wr_ready", 32'(bus.byte_ready), 32'd0);
    w = frame_words[1];
    send_byte(w[7:0], 1'b0);
    pulse_start();
    send_byte(w[15:8], 1'b0);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_error", 32'(error), 32'd0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset_values("midrst");
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_nwr", 32'(n_wr - base), 32'd1);
    check("midrst_addr0", 32'(log_addr[base]), 32'd0);
    check("midrst_data0", log_data[base], 32'hD280_0020);
    check("midrst_idle_ready", 32'(bus.byte_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
